// File: rtl/pe_ss_accum.sv
// ---------------------------------------------------------------------------
// pe_ss_accum : shift-and-accumulate stage of a PE partial-sum pad.
//
// Each accepted item reads the psum pad entry at in_addr_i. It optionally
// zeroes the old value (fstpix) and optionally shifts it left by
// (1 << in_sht_num_i). It then adds the sign-extended product and writes the
// result back. lstpix items also present the result on the output handshake.
//
// Pipeline: the accept edge loads S1 and the registered pad read. S1 does the
// arithmetic during the following cycle. The pad write and the output load
// happen on the next edge. A result written on the same edge that a new item
// reads that address is forwarded, so back-to-back accumulation is exact.
//
// Configuration macro:
//   PE_SS_SAT_EN  defined   -> sum saturates to the signed PSUM_DWD range
//                 undefined -> sum wraps modulo 2^PSUM_DWD
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid_i/ready_o input handshake (in_ready_o is combinational)
//   in_data_i          signed Aunit product (AU_ODWD)
//   in_addr_i          psum pad entry
//   in_fstpix_i        treat old psum as zero
//   in_lstpix_i        emit the finished psum
//   in_sht_i           shift old psum before the add
//   in_sht_num_i       shift code, amount = 1 << code
//   out_valid_o/ready_i output handshake
//   out_data_o         finished psum
//   out_addr_o         pad entry of the finished psum
// ---------------------------------------------------------------------------
module pe_ss_accum #(
    parameter int unsigned PSUM_DWD  = 16,
    parameter int unsigned AU_ODWD   = 16,
    parameter int unsigned PPAD_SIZE = 64,
    parameter int unsigned SHT_WD    = 2,
    localparam int unsigned PPAD_AWD = $clog2(PPAD_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic signed [AU_ODWD-1:0]  in_data_i,
    input  logic [PPAD_AWD-1:0]        in_addr_i,
    input  logic                       in_fstpix_i,
    input  logic                       in_lstpix_i,
    input  logic                       in_sht_i,
    input  logic [SHT_WD-1:0]          in_sht_num_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PSUM_DWD-1:0]        out_data_o,
    output logic [PPAD_AWD-1:0]        out_addr_o
);

`ifdef PE_SS_SAT_EN
    // Wide enough for old << (PSUM_DWD-1) plus the product without overflow.
    localparam int unsigned SUM_WD = 2 * PSUM_DWD + 1;
    localparam logic signed [SUM_WD-1:0] W_MAX =
        {{(SUM_WD - PSUM_DWD + 1){1'b0}}, {(PSUM_DWD - 1){1'b1}}};
    localparam logic signed [SUM_WD-1:0] W_MIN = ~W_MAX;
    localparam logic signed [PSUM_DWD-1:0] P_MAX = {1'b0, {(PSUM_DWD - 1){1'b1}}};
    localparam logic signed [PSUM_DWD-1:0] P_MIN = ~P_MAX;
`endif

    // S1 pipeline register
    logic                       s1_valid_q, s1_valid_d;
    logic signed [AU_ODWD-1:0]  s1_data_q;
    logic [PPAD_AWD-1:0]        s1_addr_q;
    logic                       s1_fst_q;
    logic                       s1_lst_q;
    logic                       s1_sht_q;
    logic [SHT_WD-1:0]          s1_sht_num_q;
    logic signed [PSUM_DWD-1:0] s1_old_q, s1_old_d;

    // Output register
    logic                       out_valid_q, out_valid_d;
    logic [PSUM_DWD-1:0]        out_data_q, out_data_d;
    logic [PPAD_AWD-1:0]        out_addr_q, out_addr_d;

    // Psum pad
    logic [PSUM_DWD-1:0]        pad_q [PPAD_SIZE];

    logic                       stall_c;
    logic                       s1_fire_c;
    logic                       in_fire_c;
    logic signed [PSUM_DWD-1:0] s1_new_c;
    logic signed [PSUM_DWD-1:0] old_eff_c;
    logic signed [PSUM_DWD-1:0] data_ext_c;
    logic [31:0]                sht_amt_c;
`ifdef PE_SS_SAT_EN
    logic signed [SUM_WD-1:0]   wide_c;
`else
    logic signed [PSUM_DWD-1:0] shifted_c;
`endif

    // Handshake control: S1 can only retire an lstpix item if the output slot frees up.
    always_comb begin
        stall_c    = s1_valid_q && s1_lst_q && out_valid_q && !out_ready_i;
        in_ready_o = rst_n && !stall_c;
        s1_fire_c  = s1_valid_q && !stall_c;
        in_fire_c  = in_valid_i && in_ready_o;
    end

    // S1 arithmetic: (fst ? 0 : old) << amt + sext(data)
    always_comb begin
        old_eff_c  = s1_fst_q ? '0 : s1_old_q;
        sht_amt_c  = s1_sht_q ? (32'd1 << s1_sht_num_q) : 32'd0;
        data_ext_c = PSUM_DWD'(s1_data_q);
`ifdef PE_SS_SAT_EN
        wide_c   = (SUM_WD'(old_eff_c) <<< sht_amt_c) + SUM_WD'(s1_data_q);
        s1_new_c = PSUM_DWD'(wide_c);
        if ((sht_amt_c >= 32'(PSUM_DWD)) && (old_eff_c != '0)) begin
            // Any non-zero value shifted this far is beyond range whatever the product.
            s1_new_c = old_eff_c[PSUM_DWD-1] ? P_MIN : P_MAX;
        end else if (wide_c > W_MAX) begin
            s1_new_c = P_MAX;
        end else if (wide_c < W_MIN) begin
            s1_new_c = P_MIN;
        end
`else
        shifted_c = (sht_amt_c >= 32'(PSUM_DWD)) ? '0 : (old_eff_c << sht_amt_c);
        s1_new_c  = shifted_c + data_ext_c;
`endif
    end

    // Next-state for S1 and the output register
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_old_d    = s1_old_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;

        if (in_fire_c) begin
            s1_valid_d = 1'b1;
            // Forward the result being written this edge to a reader of the same entry.
            if (s1_fire_c && (s1_addr_q == in_addr_i)) begin
                s1_old_d = s1_new_c;
            end else begin
                s1_old_d = pad_q[in_addr_i];
            end
        end else if (s1_fire_c) begin
            s1_valid_d = 1'b0;
        end

        if (s1_fire_c && s1_lst_q) begin
            out_valid_d = 1'b1;
            out_data_d  = s1_new_c;
            out_addr_d  = s1_addr_q;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers and pad
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_addr_q    <= '0;
            s1_fst_q     <= 1'b0;
            s1_lst_q     <= 1'b0;
            s1_sht_q     <= 1'b0;
            s1_sht_num_q <= '0;
            s1_old_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            for (int i = 0; i < int'(PPAD_SIZE); i++) begin
                pad_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_old_q    <= s1_old_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            if (in_fire_c) begin
                s1_data_q    <= in_data_i;
                s1_addr_q    <= in_addr_i;
                s1_fst_q     <= in_fstpix_i;
                s1_lst_q     <= in_lstpix_i;
                s1_sht_q     <= in_sht_i;
                s1_sht_num_q <= in_sht_num_i;
            end
            if (s1_fire_c) begin
                pad_q[s1_addr_q] <= s1_new_c;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_addr_o  = out_addr_q;

endmodule

// File: tb/tb_pe_ss_accum.sv
// ---------------------------------------------------------------------------
// tb_pe_ss_accum : self-checking bench for pe_ss_accum (default parameters).
// A reference pad and an expected-output queue are updated in acceptance
// order. Each output handshake is compared against the head of the queue.
// ---------------------------------------------------------------------------
module tb_pe_ss_accum;

    localparam int PSUM_DWD = 16;
    localparam int AWD      = 6;
    localparam int PSIZE    = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_data = '0;
    logic [AWD-1:0]    in_addr = '0;
    logic              in_fst = 1'b0;
    logic              in_lst = 1'b0;
    logic              in_sht = 1'b0;
    logic [1:0]        in_sht_num = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [15:0]       out_data;
    logic [AWD-1:0]    out_addr;

    int                errors = 0;
    int                checks = 0;
    bit                rdy_rand = 1'b0;
    logic [15:0]       mpad [PSIZE];
    logic [21:0]       exp_q [$];
    logic [15:0]       last_data = '0;
    logic [AWD-1:0]    last_addr = '0;
    int                out_count = 0;

    pe_ss_accum dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_addr_i   (in_addr),
        .in_fstpix_i (in_fst),
        .in_lstpix_i (in_lst),
        .in_sht_i    (in_sht),
        .in_sht_num_i(in_sht_num),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_addr_o  (out_addr)
    );

    always #5 clk = ~clk;

    // Exact integer result of the accumulate rule, then wrap or clamp.
    function automatic logic [15:0] model_acc(logic [15:0] old, logic [15:0] d,
                                              bit f, bit s, logic [1:0] sn);
        longint o, v;
        int     amt;
        o   = f ? 64'sd0 : longint'($signed(old));
        amt = s ? (1 << sn) : 0;
        v   = o * (longint'(1) << amt) + longint'($signed(d));
`ifdef PE_SS_SAT_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`endif
        return 16'(v);
    endfunction

    // Random output back-pressure
    always @(negedge clk) begin
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Output scoreboard: a transfer happens at the next rising edge
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got data=%h addr=%0d, required no output",
                         out_data, out_addr);
            end else begin
                logic [21:0] e;
                e = exp_q.pop_front();
                if ({out_data, out_addr} !== e) begin
                    errors++;
                    $display("FAIL out_data: got data=%h addr=%0d, required data=%h addr=%0d",
                             out_data, out_addr, e[21:6], e[5:0]);
                end
            end
            last_data = out_data;
            last_addr = out_addr;
            out_count++;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < PSIZE; i++) mpad[i] = '0;
        exp_q.delete();
    endtask

    task automatic send(input logic [15:0] d, input logic [AWD-1:0] a, input bit f,
                        input bit l, input bit s, input logic [1:0] sn, output int waited);
        logic [15:0] nv;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_addr = a;
        in_fst = f; in_lst = l; in_sht = s; in_sht_num = sn;
        #1;
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            errors++; checks++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
            $fatal(1, "input handshake never completed");
        end
        nv = model_acc(mpad[a], d, f, s, sn);
        mpad[a] = nv;
        if (l) exp_q.push_back({nv, a});
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs still pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        if (out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h required 0000", out_data); end
        if (out_addr !== '0) begin errors++; $display("FAIL rst_out_addr: got %0d required 0", out_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b required 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b required 0", out_valid); end
    endtask

    task automatic test_shift_accum();
        int w;
        send(16'd3, 6'd5, 1, 0, 0, 2'd0, w);
        send(16'd1, 6'd5, 0, 0, 1, 2'd1, w);
        send(16'd2, 6'd5, 0, 1, 0, 2'd0, w);
        drain();
        checks++;
        if (last_data !== 16'd15 || last_addr !== 6'd5) begin
            errors++;
            $display("FAIL shift_accum: got data=%0d addr=%0d required data=15 addr=5", last_data, last_addr);
        end
    endtask

    task automatic test_back_to_back();
        int w, total;
        total = 0;
        send(16'd1, 6'd7, 1, 0, 0, 2'd0, w); total += w;
        send(16'd1, 6'd7, 0, 0, 0, 2'd0, w); total += w;
        send(16'd1, 6'd7, 0, 0, 0, 2'd0, w); total += w;
        send(16'd1, 6'd7, 0, 1, 0, 2'd0, w); total += w;
        drain();
        checks += 2;
        if (total != 0) begin errors++; $display("FAIL b2b_stall: waited %0d cycles required 0", total); end
        if (last_data !== 16'd4 || last_addr !== 6'd7) begin
            errors++;
            $display("FAIL b2b_result: got data=%0d addr=%0d required data=4 addr=7", last_data, last_addr);
        end
    endtask

    task automatic test_stall();
        int w, cnt0;
        cnt0 = out_count;
        out_ready = 1'b0;
        send(16'd9, 6'd2, 1, 1, 0, 2'd0, w);
        send(16'd1, 6'd2, 0, 1, 0, 2'd0, w);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks += 3;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b required 0", i, in_ready); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid: cycle %0d got %b required 1", i, out_valid); end
            if (out_data !== 16'd9) begin errors++; $display("FAIL stall_out_data: cycle %0d got %0d required 9", i, out_data); end
            @(negedge clk);
        end
        drain();
        checks += 2;
        if (out_count - cnt0 != 2) begin errors++; $display("FAIL stall_count: got %0d outputs required 2", out_count - cnt0); end
        if (last_data !== 16'd10 || last_addr !== 6'd2) begin
            errors++;
            $display("FAIL stall_second: got data=%0d addr=%0d required data=10 addr=2", last_data, last_addr);
        end
    endtask

    task automatic test_overflow();
        int w;
        logic [15:0] req;
`ifdef PE_SS_SAT_EN
        req = 16'h7FFF;
`else
        req = 16'hC000;
`endif
        send(16'h4000, 6'd10, 1, 0, 0, 2'd0, w);
        send(16'h4000, 6'd10, 0, 1, 1, 2'd0, w);
        drain();
        checks++;
        if (last_data !== req) begin errors++; $display("FAIL overflow: got %h required %h", last_data, req); end
    endtask

    task automatic test_fst_lst();
        int w;
        send(16'hFFF8, 6'd63, 1, 1, 1, 2'd3, w);
        drain();
        checks++;
        if (last_data !== 16'hFFF8 || last_addr !== 6'd63) begin
            errors++;
            $display("FAIL fst_lst: got data=%h addr=%0d required data=fff8 addr=63", last_data, last_addr);
        end
    endtask

    task automatic test_reset_mid();
        int w, cnt0;
        out_ready = 1'b1;
        send(16'd5, 6'd20, 1, 0, 0, 2'd0, w);
        send(16'd3, 6'd20, 0, 1, 0, 2'd0, w);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b required 0", out_valid); end
        cnt0 = out_count;
        send(16'd0, 6'd20, 0, 1, 0, 2'd0, w);
        drain();
        checks += 2;
        if (out_count - cnt0 != 1) begin errors++; $display("FAIL rst_mid_count: got %0d outputs required 1", out_count - cnt0); end
        if (last_data !== 16'd0 || last_addr !== 6'd20) begin
            errors++;
            $display("FAIL rst_mid_readback: got data=%0d addr=%0d required data=0 addr=20", last_data, last_addr);
        end
    endtask

    task automatic test_random();
        int w;
        logic [15:0] d;
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($signed(8'($urandom)));
            send(d, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 2'($urandom), w);
            if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_shift_accum();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_fst_lst();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
